// File: rtl/prog_timer.sv
// Programmable-period interval timer.
// It counts clocks in RUN and raises a one-cycle registered flag every
// `period` clocks. It runs in periodic or one-shot mode and keeps a wrapping
// count of expiries. The period can be loaded only while IDLE. A value of 0 is
// stored as 1, so a period of 0 never reaches the counter.
module prog_timer #(
    parameter int                 WIDTH          = 28,
    parameter logic [WIDTH-1:0]   DEFAULT_PERIOD = 28'h2FA_F080,
    parameter int                 CNT_W          = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             mode,
    input  logic             period_load,
    input  logic [WIDTH-1:0] period_in,
    output logic             flag,
    output logic             busy,
    output logic [CNT_W-1:0] exp_cnt
);

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] EXP_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [WIDTH-1:0]   cnt_q,     cnt_d;
    logic [WIDTH-1:0]   period_q,  period_d;
    logic               mode_q,    mode_d;
    logic               flag_q,    flag_d;
    logic [CNT_W-1:0]   exp_cnt_q, exp_cnt_d;

    // State register: all timer state is reset asynchronously to its idle values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= ONE;
            period_q  <= DEFAULT_PERIOD;
            mode_q    <= 1'b0;
            flag_q    <= 1'b0;
            exp_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            mode_q    <= mode_d;
            flag_q    <= flag_d;
            exp_cnt_q <= exp_cnt_d;
        end
    end

    // Next-state logic. Clear overrides everything. A period load only happens
    // in IDLE and still allows the IDLE->RUN step in the same cycle, so the new
    // period applies to the run that starts.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        mode_d    = mode_q;
        flag_d    = 1'b0;
        exp_cnt_d = exp_cnt_q;

        if (clear) begin
            state_d   = S_IDLE;
            cnt_d     = ONE;
            exp_cnt_d = '0;
        end else begin
            if (period_load && (state_q == S_IDLE)) begin
                period_d = (period_in == '0) ? ONE : period_in;
            end

            case (state_q)
                S_IDLE: begin
                    cnt_d = ONE;
                    if (enable) begin
                        state_d = S_RUN;
                        mode_d  = mode;
                    end
                end
                S_RUN: begin
                    if (!enable) begin
                        // Abort: return to IDLE without an expiry.
                        state_d = S_IDLE;
                        cnt_d   = ONE;
                    end else if (cnt_q != period_q) begin
                        cnt_d = cnt_q + ONE;
                    end else begin
                        cnt_d     = ONE;
                        flag_d    = 1'b1;
                        exp_cnt_d = exp_cnt_q + EXP_ONE;
                        if (mode_q) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // Enable must go low before another run can start.
                    cnt_d = ONE;
                    if (!enable) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = ONE;
                end
            endcase
        end
    end

    assign flag    = flag_q;
    assign busy    = (state_q == S_RUN);
    assign exp_cnt = exp_cnt_q;

endmodule

// File: tb/tb_prog_timer.sv
// Testbench for prog_timer with DEFAULT_PERIOD=5 and CNT_W=4.
// The stimulus pushes (cycle, exp_cnt) pairs for the flag pulses it expects.
// A negedge monitor pops one entry for every flag pulse. It reports any flag
// that arrives early, late, without a matching entry, or with a wrong count.
module tb_prog_timer;

    localparam int WIDTH = 28;
    localparam int CNT_W = 4;

    logic             clk;
    logic             n_rst;
    logic             enable;
    logic             clear;
    logic             mode;
    logic             period_load;
    logic [WIDTH-1:0] period_in;
    logic             flag;
    logic             busy;
    logic [CNT_W-1:0] exp_cnt;

    prog_timer #(
        .WIDTH          (WIDTH),
        .DEFAULT_PERIOD (28'd5),
        .CNT_W          (CNT_W)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .enable      (enable),
        .clear       (clear),
        .mode        (mode),
        .period_load (period_load),
        .period_in   (period_in),
        .flag        (flag),
        .busy        (busy),
        .exp_cnt     (exp_cnt)
    );

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: cyc equals k after rising edge k.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int at, input int c);
        exp_t e;
        e.cyc = at;
        e.cnt = c & 15;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
        end else begin
            $display("ok   %s cyc=%0d value=%0d", name, cyc, got);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Scoreboard monitor: compares each flag pulse with the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (flag) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_flag cyc=%0d got exp_cnt=%0d want no flag", cyc, exp_cnt);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.cnt != int'(exp_cnt)) begin
                    errors++;
                    $display("FAIL flag_pulse got cyc=%0d exp_cnt=%0d want cyc=%0d exp_cnt=%0d",
                             cyc, exp_cnt, e.cyc, e.cnt);
                end else begin
                    $display("ok   flag_pulse cyc=%0d exp_cnt=%0d", cyc, exp_cnt);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_flag got none by cyc=%0d want cyc=%0d exp_cnt=%0d", cyc, e.cyc, e.cnt);
        end
    end

    initial begin
        int e0;
        n_rst       = 1'b0;
        enable      = 1'b0;
        clear       = 1'b0;
        mode        = 1'b0;
        period_load = 1'b0;
        period_in   = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_flag", int'(flag), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_exp_cnt", int'(exp_cnt), 0);
        n_rst = 1'b1;

        // Periodic with the default period of 5
        @(negedge clk);
        mode   = 1'b0;
        enable = 1'b1;
        e0     = cyc + 1;
        push(e0 + 5, 1);
        push(e0 + 10, 2);
        push(e0 + 15, 3);
        @(negedge clk);
        check("periodic_busy", int'(busy), 1);
        wait_until(e0 + 16);
        enable = 1'b0;
        @(negedge clk);
        check("periodic_stop_busy", int'(busy), 0);
        check("periodic_exp_cnt", int'(exp_cnt), 3);

        // Clear while IDLE, then abort at cnt=4
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_idle_exp_cnt", int'(exp_cnt), 0);
        enable = 1'b1;
        e0     = cyc + 1;
        wait_until(e0 + 3);
        enable = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_exp_cnt", int'(exp_cnt), 0);
        // The next run must take a full period, which shows the abort reset cnt.
        enable = 1'b1;
        e0     = cyc + 1;
        push(e0 + 5, 1);
        push(e0 + 10, 2);
        wait_until(e0 + 12);
        clear  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        check("clear_run_busy", int'(busy), 0);
        check("clear_run_exp_cnt", int'(exp_cnt), 0);
        check("clear_run_flag", int'(flag), 0);

        // One-shot: one pulse, no retrigger until enable goes low
        mode   = 1'b1;
        enable = 1'b1;
        e0     = cyc + 1;
        push(e0 + 5, 1);
        wait_until(e0 + 4);
        check("oneshot_busy_before", int'(busy), 1);
        wait_until(e0 + 5);
        check("oneshot_busy_after", int'(busy), 0);
        wait_until(e0 + 20);
        check("oneshot_held_busy", int'(busy), 0);
        check("oneshot_held_exp_cnt", int'(exp_cnt), 1);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        e0     = cyc + 1;
        push(e0 + 5, 2);
        wait_until(e0 + 7);
        check("oneshot_rearm_busy", int'(busy), 0);
        enable = 1'b0;
        mode   = 1'b0;
        @(negedge clk);

        // Load period 3 together with enable; a load of 7 while RUN is ignored
        period_in   = 28'd3;
        period_load = 1'b1;
        enable      = 1'b1;
        e0          = cyc + 1;
        push(e0 + 3, 3);
        push(e0 + 6, 4);
        push(e0 + 9, 5);
        @(negedge clk);
        period_load = 1'b0;
        wait_until(e0 + 4);
        period_in   = 28'd7;
        period_load = 1'b1;
        @(negedge clk);
        period_load = 1'b0;
        wait_until(e0 + 10);
        enable = 1'b0;
        @(negedge clk);

        // period_in=0 is stored as 1: a flag every clock
        period_in   = '0;
        period_load = 1'b1;
        enable      = 1'b1;
        e0          = cyc + 1;
        for (int k = 1; k <= 4; k++) push(e0 + k, 5 + k);
        @(negedge clk);
        period_load = 1'b0;
        wait_until(e0 + 4);
        enable = 1'b0;
        @(negedge clk);

        // Wrap: 16 expiries with P=1 take exp_cnt from 15 back to 0
        clear = 1'b1;
        @(negedge clk);
        clear  = 1'b0;
        enable = 1'b1;
        e0     = cyc + 1;
        for (int k = 1; k <= 16; k++) push(e0 + k, k);
        wait_until(e0 + 16);
        enable = 1'b0;
        @(negedge clk);
        check("wrap_exp_cnt", int'(exp_cnt), 0);

        // Asynchronous reset mid-run restores the default period
        period_in   = 28'd3;
        period_load = 1'b1;
        enable      = 1'b1;
        e0          = cyc + 1;
        push(e0 + 3, 1);
        @(negedge clk);
        period_load = 1'b0;
        wait_until(e0 + 3);
        #2;
        n_rst = 1'b0;
        #1;
        check("async_rst_flag", int'(flag), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_exp_cnt", int'(exp_cnt), 0);
        enable = 1'b0;
        @(negedge clk);
        n_rst  = 1'b1;
        enable = 1'b1;
        e0     = cyc + 1;
        push(e0 + 5, 1);
        wait_until(e0 + 6);
        enable = 1'b0;
        repeat (3) @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_flags got %0d outstanding want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
